// File: rtl/glyph_capture.sv
// glyph_capture: captures a glyph drawer's pixel stream into a 32x32 tile bitmap
// with distinct-pixel count, bounding box and out-of-tile statistics, plus
// registered row readback.
module glyph_capture (
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        finish,
    input  logic [7:0]  xIn,
    input  logic [6:0]  yIn,
    input  logic [7:0]  pixX,
    input  logic [6:0]  pixY,
    input  logic        pixValid,
    input  logic [4:0]  rowAddr,
    output logic [31:0] rowData,
    output logic        busy,
    output logic        capturing,
    output logic        ready,
    output logic [10:0] pixelCount,
    output logic [7:0]  oobCount,
    output logic [4:0]  minX,
    output logic [4:0]  maxX,
    output logic [4:0]  minY,
    output logic [4:0]  maxY,
    output logic        boxValid
);

    localparam int unsigned TILE = 32;
    localparam int unsigned XW   = 8;
    localparam int unsigned YW   = 7;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 11;
    localparam int unsigned OW   = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_next_state;
    logic [AW-1:0]   r_row_cnt;
    logic [TILE-1:0] r_bitmap [TILE];

    logic [XW-1:0]   w_lx;
    logic [YW-1:0]   w_ly;
    logic [AW-1:0]   w_lx5;
    logic [AW-1:0]   w_ly5;
    logic            w_in_tile;
    logic            w_pix_cycle;
    logic            w_new_pixel;
    logic            w_oob_pixel;

    // Tile-local coordinates; underflow wraps large and lands out of tile.
    always_comb begin
        w_lx        = XW'(pixX - xIn);
        w_ly        = YW'(pixY - yIn);
        w_lx5       = w_lx[AW-1:0];
        w_ly5       = w_ly[AW-1:0];
        w_in_tile   = (w_lx < XW'(TILE)) && (w_ly < YW'(TILE));
        w_pix_cycle = (r_state == S_CAPTURE) && pixValid && !start;
        w_new_pixel = w_pix_cycle && w_in_tile && !r_bitmap[w_ly5][w_lx5];
        w_oob_pixel = w_pix_cycle && !w_in_tile;
    end

    // Next state; start wins over everything, including finish.
    always_comb begin
        w_next_state = r_state;
        if (start) begin
            w_next_state = S_CLEAR;
        end else begin
            case (r_state)
                S_CLEAR:   if (r_row_cnt == AW'(TILE - 1)) w_next_state = S_CAPTURE;
                S_CAPTURE: if (finish) w_next_state = S_DONE;
                default:   w_next_state = r_state;
            endcase
        end
    end

    // State register, clear row counter and state-decoded status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= S_IDLE;
            r_row_cnt <= '0;
            busy      <= 1'b0;
            capturing <= 1'b0;
            ready     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            busy      <= (w_next_state == S_CLEAR);
            capturing <= (w_next_state == S_CAPTURE);
            ready     <= (w_next_state == S_DONE);
            if (start) begin
                r_row_cnt <= '0;
            end else if (r_state == S_CLEAR) begin
                r_row_cnt <= AW'(r_row_cnt + AW'(1));
            end
        end
    end

    // Bitmap storage: one row zeroed per CLEAR cycle, single-bit set per accepted pixel.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < int'(TILE); i++) begin
                r_bitmap[i] <= '0;
            end
        end else if (r_state == S_CLEAR && !start) begin
            r_bitmap[r_row_cnt] <= '0;
        end else if (w_new_pixel) begin
            r_bitmap[w_ly5][w_lx5] <= 1'b1;
        end
    end

    // Capture statistics; cleared on start, updated only by first-time pixels.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pixelCount <= '0;
            oobCount   <= '0;
            minX       <= AW'(TILE - 1);
            minY       <= AW'(TILE - 1);
            maxX       <= '0;
            maxY       <= '0;
            boxValid   <= 1'b0;
        end else if (start) begin
            pixelCount <= '0;
            oobCount   <= '0;
            minX       <= AW'(TILE - 1);
            minY       <= AW'(TILE - 1);
            maxX       <= '0;
            maxY       <= '0;
            boxValid   <= 1'b0;
        end else begin
            if (w_new_pixel) begin
                pixelCount <= CW'(pixelCount + CW'(1));
                boxValid   <= 1'b1;
                if (w_lx5 < minX) minX <= w_lx5;
                if (w_lx5 > maxX) maxX <= w_lx5;
                if (w_ly5 < minY) minY <= w_ly5;
                if (w_ly5 > maxY) maxY <= w_ly5;
            end
            if (w_oob_pixel && (oobCount != OW'(255))) begin
                oobCount <= OW'(oobCount + OW'(1));
            end
        end
    end

    // Registered readback; returns pre-write contents when a row is being written.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rowData <= '0;
        end else begin
            rowData <= r_bitmap[rowAddr];
        end
    end

endmodule

// File: tb/tb_glyph_capture.sv
// Bench for glyph_capture: directed stimulus with a reference bitmap model and
// a scoreboard queue of expected values popped as DUT outputs are sampled.
module tb_glyph_capture;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        finish = 1'b0;
    logic [7:0]  xIn = '0;
    logic [6:0]  yIn = '0;
    logic [7:0]  pixX = '0;
    logic [6:0]  pixY = '0;
    logic        pixValid = 1'b0;
    logic [4:0]  rowAddr = '0;
    logic [31:0] rowData;
    logic        busy, capturing, ready, boxValid;
    logic [10:0] pixelCount;
    logic [7:0]  oobCount;
    logic [4:0]  minX, maxX, minY, maxY;

    glyph_capture dut (
        .clk(clk), .resetn(resetn), .start(start), .finish(finish),
        .xIn(xIn), .yIn(yIn), .pixX(pixX), .pixY(pixY), .pixValid(pixValid),
        .rowAddr(rowAddr), .rowData(rowData), .busy(busy), .capturing(capturing),
        .ready(ready), .pixelCount(pixelCount), .oobCount(oobCount),
        .minX(minX), .maxX(maxX), .minY(minY), .maxY(maxY), .boxValid(boxValid)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          n_pass = 0;
    int          n_total = 0;

    logic [31:0] m_bmp [32];
    int          m_cnt, m_oob;
    logic [4:0]  m_minx, m_maxx, m_miny, m_maxy;
    logic        m_cap = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_chk(input logic [31:0] obs);
        exp_t e;
        n_total++;
        if (sb.size() == 0) begin
            $error("FAIL scoreboard_empty observed=%0h expected=<entry>", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) m_bmp[i] = '0;
        m_cnt  = 0;
        m_oob  = 0;
        m_minx = 5'd31;
        m_miny = 5'd31;
        m_maxx = 5'd0;
        m_maxy = 5'd0;
    endtask

    task automatic model_pix(input logic [7:0] x, input logic [6:0] y);
        logic [7:0] lx;
        logic [6:0] ly;
        if (!m_cap) return;
        lx = 8'(x - xIn);
        ly = 7'(y - yIn);
        if (lx < 8'd32 && ly < 7'd32) begin
            if (!m_bmp[ly[4:0]][lx[4:0]]) begin
                m_bmp[ly[4:0]][lx[4:0]] = 1'b1;
                m_cnt++;
                if (lx[4:0] < m_minx) m_minx = lx[4:0];
                if (lx[4:0] > m_maxx) m_maxx = lx[4:0];
                if (ly[4:0] < m_miny) m_miny = ly[4:0];
                if (ly[4:0] > m_maxy) m_maxy = ly[4:0];
            end
        end else if (m_oob < 255) begin
            m_oob++;
        end
    endtask

    task automatic send_pix(input logic [7:0] x, input logic [6:0] y);
        pixX = x;
        pixY = y;
        pixValid = 1'b1;
        model_pix(x, y);
        step();
        pixValid = 1'b0;
    endtask

    task automatic read_row(input int r);
        rowAddr = 5'(r);
        push($sformatf("row%0d", r), m_bmp[r]);
        step();
        pop_chk(rowData);
    endtask

    task automatic chk_stats();
        push("pixelCount", 32'(m_cnt));
        push("oobCount", 32'(m_oob));
        push("minX", 32'(m_minx));
        push("maxX", 32'(m_maxx));
        push("minY", 32'(m_miny));
        push("maxY", 32'(m_maxy));
        push("boxValid", 32'(m_cnt != 0));
        pop_chk(32'(pixelCount));
        pop_chk(32'(oobCount));
        pop_chk(32'(minX));
        pop_chk(32'(maxX));
        pop_chk(32'(minY));
        pop_chk(32'(maxY));
        pop_chk(32'(boxValid));
    endtask

    // Start a capture and wait (bounded) for the CLEAR phase to end.
    task automatic do_start();
        int nb;
        nb = 0;
        start = 1'b1;
        m_cap = 1'b0;
        model_clear();
        step();
        start = 1'b0;
        for (int i = 0; i < 40 && !capturing; i++) begin
            if (busy) nb++;
            step();
        end
        push("busy_cycles", 32'd32);
        push("capturing_up", 32'd1);
        push("busy_dropped", 32'd0);
        pop_chk(32'(nb));
        pop_chk(32'(capturing));
        pop_chk(32'(busy));
        m_cap = 1'b1;
    endtask

    task automatic do_finish();
        finish = 1'b1;
        step();
        finish = 1'b0;
        m_cap = 1'b0;
        push("ready", 32'd1);
        push("capturing_down", 32'd0);
        pop_chk(32'(ready));
        pop_chk(32'(capturing));
    endtask

    // Asynchronous reset pulse, checked before any clock edge arrives.
    task automatic async_reset();
        @(negedge clk);
        resetn = 1'b0;
        #1;
        m_cap = 1'b0;
        model_clear();
        push("rst_busy", 32'd0);
        push("rst_capturing", 32'd0);
        push("rst_ready", 32'd0);
        push("rst_rowData", 32'd0);
        pop_chk(32'(busy));
        pop_chk(32'(capturing));
        pop_chk(32'(ready));
        pop_chk(rowData);
        chk_stats();
        step();
        resetn = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        model_clear();
        repeat (2) step();
        resetn = 1'b1;

        // Reset then idle
        for (int r = 0; r < 32; r++) read_row(r);
        chk_stats();
        push("idle_ready", 32'd0);
        pop_chk(32'(ready));
        send_pix(8'd3, 7'd3);
        send_pix(8'd10, 7'd0);
        send_pix(8'd200, 7'd100);
        chk_stats();
        read_row(3);
        read_row(0);

        // Horizontal bar
        xIn = 8'd40;
        yIn = 7'd20;
        do_start();
        for (int x = 57; x <= 62; x++) send_pix(8'(x), 7'd34);
        do_finish();
        read_row(14);
        push("row14_bar", 32'h007E0000);
        pop_chk(rowData);
        chk_stats();

        // Vertical line streamed twice plus a repeated single pixel
        do_start();
        repeat (2) for (int y = 27; y <= 41; y++) send_pix(8'd48, 7'(y));
        repeat (10) send_pix(8'd71, 7'd40);
        do_finish();
        chk_stats();
        push("pc16", 32'd16);
        pop_chk(32'(pixelCount));
        for (int r = 0; r < 32; r++) read_row(r);
        read_row(20);
        push("row20_const", 32'h80000100);
        pop_chk(rowData);

        // Out-of-tile hits with saturation
        do_start();
        send_pix(8'd39, 7'd20);
        send_pix(8'd72, 7'd20);
        send_pix(8'd40, 7'd52);
        repeat (300) send_pix(8'd0, 7'd0);
        do_finish();
        chk_stats();
        push("oob_sat", 32'd255);
        pop_chk(32'(oobCount));
        read_row(0);
        read_row(20);

        // finish together with a pixel, then restart right away
        xIn = 8'd0;
        yIn = 7'd0;
        do_start();
        finish = 1'b1;
        send_pix(8'd5, 7'd5);
        finish = 1'b0;
        m_cap = 1'b0;
        push("ready_fin_pix", 32'd1);
        pop_chk(32'(ready));
        read_row(5);
        push("row5_bit5", 32'h00000020);
        pop_chk(rowData);
        chk_stats();
        do_start();
        read_row(5);
        chk_stats();
        do_finish();

        // Reset during the 10th CLEAR cycle
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (9) step();
        async_reset();
        do_start();
        send_pix(8'd1, 7'd2);
        do_finish();
        read_row(2);
        chk_stats();

        // Reset mid-capture with the written row selected for readback
        do_start();
        send_pix(8'd7, 7'd9);
        send_pix(8'd8, 7'd9);
        read_row(9);
        async_reset();
        do_start();
        send_pix(8'd30, 7'd31);
        do_finish();
        read_row(9);
        read_row(31);
        chk_stats();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
